// File: rtl/memory_cycle_if.sv
// Data-memory bus between the MEM stage and an external memory:
// a registered request with a one-cycle acknowledge pulse.
interface memory_cycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_cycle.sv
// MIPS memory stage: runs loads/stores over a variable-latency req/ack bus,
// stalls the pipeline while an access is outstanding and drives MEM/WB.
module memory_cycle #(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic                  BranchM,
  input  logic                  ZeroM,
  input  logic [31:0]           ALUOutM,
  input  logic [31:0]           WriteDataM,
  input  logic [4:0]            WriteRegM,
  output logic                  PCSrcM,
  output logic                  StallM,
  memory_cycle_if.master        mem,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [31:0]           ReadDataW,
  output logic [31:0]           ALUOutW,
  output logic [4:0]            WriteRegW,
  output logic                  AlignErrW,
  output logic                  BusErrW
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_rbuf;
  logic        r_bus_err_pend;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;

  logic        r_reg_write_w, r_memto_reg_w, r_align_err_w, r_bus_err_w;
  logic [31:0] r_read_data_w, r_alu_out_w;
  logic [4:0]  r_write_reg_w;

  logic        w_access, w_misaligned, w_timeout;
  logic        w_stall, w_issue, w_capture, w_abort, w_cnt_inc;
  logic        w_reg_write_w, w_memto_reg_w, w_align_err_w, w_bus_err_w;
  logic [31:0] w_read_data_w;

  assign w_access     = MemtoRegM | MemWriteM;
  assign w_misaligned = (ALUOutM[1:0] != 2'b00);
  assign w_timeout    = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_stall       = 1'b0;
    w_issue       = 1'b0;
    w_capture     = 1'b0;
    w_abort       = 1'b0;
    w_cnt_inc     = 1'b0;
    w_reg_write_w = 1'b0;
    w_memto_reg_w = 1'b0;
    w_align_err_w = 1'b0;
    w_bus_err_w   = 1'b0;
    w_read_data_w = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_access && !w_misaligned) begin
          w_stall      = 1'b1;
          w_issue      = 1'b1;
          w_state_next = S_REQ;
        end else if (w_access) begin
          w_align_err_w = 1'b1;
        end else begin
          w_reg_write_w = RegWriteM;
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        // An ack in the final counted cycle still wins over the timeout.
        if (mem.mem_ack) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        if (r_bus_err_pend) begin
          w_bus_err_w = 1'b1;
        end else begin
          w_reg_write_w = RegWriteM;
          w_memto_reg_w = MemtoRegM;
          w_read_data_w = MemtoRegM ? r_rbuf : 32'd0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 8'd0;
      r_rbuf         <= 32'd0;
      r_bus_err_pend <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= 32'd0;
      r_mem_wdata    <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_mem_req      <= 1'b1;
        r_mem_we       <= MemWriteM & ~MemtoRegM;
        r_mem_addr     <= {ALUOutM[31:2], 2'b00};
        r_mem_wdata    <= WriteDataM;
        r_cnt          <= 8'd0;
        r_bus_err_pend <= 1'b0;
      end
      if (w_capture) begin
        r_mem_req <= 1'b0;
        r_rbuf    <= mem.mem_rdata;
      end
      if (w_abort) begin
        r_mem_req      <= 1'b0;
        r_bus_err_pend <= 1'b1;
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write_w <= 1'b0;
      r_memto_reg_w <= 1'b0;
      r_read_data_w <= 32'd0;
      r_alu_out_w   <= 32'd0;
      r_write_reg_w <= 5'd0;
      r_align_err_w <= 1'b0;
      r_bus_err_w   <= 1'b0;
    end else begin
      r_reg_write_w <= w_reg_write_w;
      r_memto_reg_w <= w_memto_reg_w;
      r_read_data_w <= w_read_data_w;
      r_alu_out_w   <= ALUOutM;
      r_write_reg_w <= WriteRegM;
      r_align_err_w <= w_align_err_w;
      r_bus_err_w   <= w_bus_err_w;
    end
  end

  assign PCSrcM        = BranchM & ZeroM;
  assign StallM        = w_stall;
  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign RegWriteW     = r_reg_write_w;
  assign MemtoRegW     = r_memto_reg_w;
  assign ReadDataW     = r_read_data_w;
  assign ALUOutW       = r_alu_out_w;
  assign WriteRegW     = r_write_reg_w;
  assign AlignErrW     = r_align_err_w;
  assign BusErrW       = r_bus_err_w;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: single-cycle vector table plus
// hand-written load/store/timeout/reset sequences.
module tb_memory_cycle;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        PCSrcM, StallM;
  logic        RegWriteW, MemtoRegW, AlignErrW, BusErrW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  memory_cycle_if bus();

  memory_cycle #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .BranchM(BranchM), .ZeroM(ZeroM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .PCSrcM(PCSrcM), .StallM(StallM),
    .mem(bus),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .AlignErrW(AlignErrW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_nop();
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0; BranchM = 0; ZeroM = 0;
    ALUOutM = 0; WriteDataM = 0; WriteRegM = 0;
  endtask

  // Runs one aligned access from IDLE to the DONE->IDLE edge, acking in the
  // ack_at-th REQ cycle (counted from 0), or never when ack_at < 0.
  task automatic do_access(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_at,
                           input logic [31:0] rdata,
                           output int stall_n, output int req_n);
    int  reqcyc;
    logic s;
    logic done;
    stall_n = 0; req_n = 0; reqcyc = 0; done = 0;
    MemtoRegM = ld; MemWriteM = st; ALUOutM = addr; WriteDataM = wdata;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      s = StallM;
      if (s) stall_n++;
      if (bus.mem_req) begin
        req_n++;
        chk("mem_addr_stable", bus.mem_addr, addr);
        chk("mem_wdata_stable", bus.mem_wdata, wdata);
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, st & ~ld});
        if (reqcyc == ack_at) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rdata;
        end
        reqcyc++;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (!s) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_bound: got no completion expected completion within 40 cycles");
    end
  endtask

  typedef struct {
    logic        rw, m2r, mw, br, z;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        e_pcsrc, e_rw, e_align;
    logic [31:0] e_alu;
    logic [4:0]  e_wr;
  } vec_t;

  vec_t vecs[7];
  int   sn, rn;

  initial begin
    vecs[0] = '{1, 0, 0, 1, 1, 32'h7,        5'd3,  1, 1, 0, 32'h7,        5'd3};
    vecs[1] = '{0, 0, 0, 1, 0, 32'hFFFFFFFC, 5'd1,  0, 0, 0, 32'hFFFFFFFC, 5'd1};
    vecs[2] = '{1, 0, 0, 0, 1, 32'h12345678, 5'd31, 0, 1, 0, 32'h12345678, 5'd31};
    vecs[3] = '{1, 1, 0, 0, 0, 32'h102,      5'd5,  0, 0, 1, 32'h102,      5'd5};
    vecs[4] = '{0, 0, 1, 0, 0, 32'h203,      5'd6,  0, 0, 1, 32'h203,      5'd6};
    vecs[5] = '{1, 1, 1, 1, 1, 32'h001,      5'd7,  1, 0, 1, 32'h001,      5'd7};
    vecs[6] = '{1, 0, 0, 0, 0, 32'h0,        5'd0,  0, 1, 0, 32'h0,        5'd0};

    rst = 1'b0;
    drive_nop();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    #12;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("rst_ALUOutW", ALUOutW, 32'd0);
    chk("rst_StallM", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      RegWriteM = vecs[i].rw; MemtoRegM = vecs[i].m2r; MemWriteM = vecs[i].mw;
      BranchM = vecs[i].br; ZeroM = vecs[i].z; ALUOutM = vecs[i].alu;
      WriteRegM = vecs[i].wr; WriteDataM = 32'hA5A5A5A5;
      #1;
      chk("vec_PCSrcM", {31'd0, PCSrcM}, {31'd0, vecs[i].e_pcsrc});
      chk("vec_StallM", {31'd0, StallM}, 32'd0);
      @(posedge clk); #1;
      chk("vec_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("vec_RegWriteW", {31'd0, RegWriteW}, {31'd0, vecs[i].e_rw});
      chk("vec_MemtoRegW", {31'd0, MemtoRegW}, 32'd0);
      chk("vec_ALUOutW", ALUOutW, vecs[i].e_alu);
      chk("vec_WriteRegW", {27'd0, WriteRegW}, {27'd0, vecs[i].e_wr});
      chk("vec_AlignErrW", {31'd0, AlignErrW}, {31'd0, vecs[i].e_align});
      chk("vec_BusErrW", {31'd0, BusErrW}, 32'd0);
      chk("vec_ReadDataW", ReadDataW, 32'd0);
      $display("vec %0d alu=%h pcsrc=%b regwritew=%b alignerr=%b", i, vecs[i].alu,
               PCSrcM, RegWriteW, AlignErrW);
    end

    // Load with ack in the first REQ cycle.
    drive_nop(); RegWriteM = 1; WriteRegM = 5'd9;
    do_access(1, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, sn, rn);
    chk("load_stall_cycles", sn, 2);
    chk("load_req_cycles", rn, 1);
    chk("load_ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("load_MemtoRegW", {31'd0, MemtoRegW}, 32'd1);
    chk("load_RegWriteW", {31'd0, RegWriteW}, 32'd1);
    chk("load_WriteRegW", {27'd0, WriteRegW}, 32'd9);
    chk("load_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
    $display("load addr=100 stall=%0d req=%0d rdata=%h", sn, rn, ReadDataW);
    drive_nop(); #1;

    // Store acked in the fourth REQ cycle.
    RegWriteM = 0; WriteRegM = 5'd2;
    do_access(0, 1, 32'h24, 32'h12345678, 3, 32'hFFFFFFFF, sn, rn);
    chk("store_stall_cycles", sn, 5);
    chk("store_req_cycles", rn, 4);
    chk("store_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("store_ReadDataW", ReadDataW, 32'd0);
    chk("store_BusErrW", {31'd0, BusErrW}, 32'd0);
    $display("store addr=24 stall=%0d req=%0d", sn, rn);
    drive_nop(); #1;

    // Load that is never acked.
    RegWriteM = 1; WriteRegM = 5'd8;
    do_access(1, 0, 32'h40, 32'h0, -1, 32'h0, sn, rn);
    chk("timeout_req_cycles", rn, TO);
    chk("timeout_stall_cycles", sn, TO + 1);
    chk("timeout_BusErrW", {31'd0, BusErrW}, 32'd1);
    chk("timeout_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("timeout_MemtoRegW", {31'd0, MemtoRegW}, 32'd0);
    drive_nop();
    #1;
    chk("timeout_idle_StallM", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    chk("timeout_BusErrW_clear", {31'd0, BusErrW}, 32'd0);
    $display("timeout stall=%0d req=%0d", sn, rn);

    // Asynchronous reset while a request is outstanding.
    RegWriteM = 1; WriteRegM = 5'd4; MemtoRegM = 1; ALUOutM = 32'h100;
    @(posedge clk); #1;
    chk("rstreq_mem_req_high", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk); #1;
    drive_nop(); #1;
    chk("rstreq_StallM_before", {31'd0, StallM}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstreq_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rstreq_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("rstreq_ALUOutW", ALUOutW, 32'd0);
    chk("rstreq_StallM", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD0BAD;
    #1;
    chk("late_ack_StallM", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("late_ack_ReadDataW", ReadDataW, 32'd0);
    chk("late_ack_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    $display("reset in REQ: mem_req=%b stall=%b", bus.mem_req, StallM);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
